// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch queue.
//   INST_W           : instruction and address width
//   DEFAULT_RESET_PC : default first fetch address after reset
//   fetch_state_e    : request FSM states (idle / waiting for ack / dropping stale ack)
package fetch_pkg;

    localparam int unsigned INST_W = 32;
    localparam logic [INST_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StDrop = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched {pc, inst} pairs.
//   clk, rst      : clock, asynchronous active-low reset
//   flush         : empties the FIFO; has priority over push and pop
//   push, wdata   : write one entry (ignored when full)
//   pop           : drop the head entry (ignored when empty)
//   rdata         : head entry, zero when empty
//   count, full, empty : occupancy status
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign count   = count_q;
    // Gate the head so the outputs read zero whenever nothing is queued.
    assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue with a single outstanding memory request.
//   clk, rst                 : clock, asynchronous active-low reset
//   redirect, redirect_pc    : flush the queue and restart fetch at redirect_pc (word aligned)
//   imem_req, imem_addr      : registered read request, held until imem_ack
//   imem_ack, imem_rdata     : request completion and returned word
//   inst_valid, inst_ready   : head handshake towards the datapath
//   inst, inst_pc            : head instruction and its address
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned       DEPTH    = 4,
    parameter logic [INST_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect,
    input  logic [INST_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [INST_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [INST_W-1:0] inst_pc
);

    fetch_state_e      state_q, state_d;
    logic [INST_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [INST_W-1:0] addr_q, addr_d;
    logic              req_q, req_d;
    logic [INST_W-1:0] redirect_pc_al;

    logic                    push, pop, flush, full, empty;
    logic [2*INST_W-1:0]     head;
    logic [$clog2(DEPTH):0]  count;

    assign redirect_pc_al = {redirect_pc[INST_W-1:2], 2'b00};
    assign imem_req       = req_q;
    assign imem_addr      = addr_q;
    assign inst_valid     = ~empty;
    assign inst_pc        = head[2*INST_W-1:INST_W];
    assign inst           = head[INST_W-1:0];
    // A redirect flushes the queue, so a simultaneous pop is meaningless.
    assign pop            = inst_valid & inst_ready & ~redirect;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        req_d      = req_q;
        push       = 1'b0;
        flush      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (redirect) begin
                    flush      = 1'b1;
                    fetch_pc_d = redirect_pc_al;
                end else if (!full) begin
                    // Registered count: a slot is reserved for the one request in flight.
                    state_d = StWait;
                    req_d   = 1'b1;
                    addr_d  = fetch_pc_q;
                end
            end
            StWait: begin
                if (redirect) begin
                    flush      = 1'b1;
                    fetch_pc_d = redirect_pc_al;
                    if (imem_ack) begin
                        state_d = StIdle;
                        req_d   = 1'b0;
                    end else begin
                        // Request must still complete; its data is thrown away.
                        state_d = StDrop;
                    end
                end else if (imem_ack) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = StIdle;
                    req_d      = 1'b0;
                end
            end
            StDrop: begin
                if (redirect) begin
                    fetch_pc_d = redirect_pc_al;
                end
                if (imem_ack) begin
                    state_d = StIdle;
                    req_d   = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC;
            addr_q     <= '0;
            req_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            req_q      <= req_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * INST_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .wdata ({fetch_pc_q, imem_rdata}),
        .pop   (pop),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    int          n_pass = 0;
    int          n_total = 0;
    int          mem_wait = 0;
    int          wait_cnt;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F ^ {a[15:0], a[31:16]};
    endfunction

    // Memory model: acks after mem_wait extra cycles of a held request.
    assign imem_ack   = imem_req && (wait_cnt == mem_wait);
    assign imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) wait_cnt <= 0;
        else if (imem_ack) wait_cnt <= 0;
        else if (imem_req) wait_cnt <= wait_cnt + 1;
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        redirect = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        n_total++; if (imem_req !== 1'b0) $display("FAIL reset_req got=%b exp=0", imem_req); else n_pass++;
        n_total++; if (inst_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", inst_valid); else n_pass++;
        n_total++; if (inst !== 32'h0) $display("FAIL reset_inst got=%h exp=0", inst); else n_pass++;
        n_total++; if (inst_pc !== 32'h0) $display("FAIL reset_pc got=%h exp=0", inst_pc); else n_pass++;
    endtask

    task automatic test_stream();
        logic [63:0] e;
        int last;
        mem_wait = 0;
        inst_ready = 1'b1;
        exp_q.delete();
        do_reset();
        n_total++; if (imem_req !== 1'b1) $display("FAIL first_req got=%b exp=1", imem_req); else n_pass++;
        n_total++; if (imem_addr !== 32'h0) $display("FAIL first_addr got=%h exp=0", imem_addr); else n_pass++;
        for (int i = 0; i < 4; i++) exp_q.push_back({32'(i * 4), mem_word(32'(i * 4))});
        last = -1;
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            if (inst_valid && inst_ready) begin
                e = exp_q.pop_front();
                n_total++;
                if ({inst_pc, inst} !== e) $display("FAIL stream_pop got=%h/%h exp=%h/%h", inst_pc, inst, e[63:32], e[31:0]);
                else n_pass++;
                if (last >= 0) begin
                    n_total++;
                    if (c - last != 2) $display("FAIL stream_gap got=%0d exp=2", c - last); else n_pass++;
                end
                last = c;
            end
            @(negedge clk);
        end
        n_total++; if (exp_q.size() != 0) $display("FAIL stream_timeout left=%0d exp=0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [63:0] e;
        int acks;
        logic got;
        logic [31:0] first_addr;
        mem_wait = 0;
        inst_ready = 1'b0;
        exp_q.delete();
        do_reset();
        acks = 0;
        for (int c = 0; c < 20; c++) begin
            if (imem_req && imem_ack) acks++;
            @(negedge clk);
        end
        n_total++; if (acks != 4) $display("FAIL bp_requests got=%0d exp=4", acks); else n_pass++;
        n_total++; if (imem_req !== 1'b0) $display("FAIL bp_req_low got=%b exp=0", imem_req); else n_pass++;
        n_total++; if (inst_valid !== 1'b1) $display("FAIL bp_valid got=%b exp=1", inst_valid); else n_pass++;
        for (int i = 0; i < 4; i++) exp_q.push_back({32'(i * 4), mem_word(32'(i * 4))});
        inst_ready = 1'b1;
        got = 1'b0;
        first_addr = '0;
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            if (imem_req && !got) begin
                got = 1'b1;
                first_addr = imem_addr;
            end
            if (inst_valid && inst_ready) begin
                e = exp_q.pop_front();
                n_total++;
                if ({inst_pc, inst} !== e) $display("FAIL bp_pop got=%h/%h exp=%h/%h", inst_pc, inst, e[63:32], e[31:0]);
                else n_pass++;
            end
            @(negedge clk);
        end
        n_total++; if (exp_q.size() != 0) $display("FAIL bp_timeout left=%0d exp=0", exp_q.size()); else n_pass++;
        n_total++; if (!got || first_addr !== 32'h10) $display("FAIL bp_resume got=%h seen=%b exp=00000010", first_addr, got); else n_pass++;
    endtask

    task automatic test_drop();
        logic [63:0] e;
        logic [31:0] ack_addr[$];
        mem_wait = 3;
        inst_ready = 1'b1;
        exp_q.delete();
        do_reset();
        n_total++; if (!(imem_req && !imem_ack)) $display("FAIL drop_setup got=%b%b exp=10", imem_req, imem_ack); else n_pass++;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0103;
        @(negedge clk);
        redirect = 1'b0;
        n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL drop_hold got=%b/%h exp=1/00000000", imem_req, imem_addr); else n_pass++;
        exp_q.push_back({32'h100, mem_word(32'h100)});
        for (int c = 0; c < 40 && (exp_q.size() > 0 || ack_addr.size() < 2); c++) begin
            if (imem_req && imem_ack) ack_addr.push_back(imem_addr);
            if (inst_valid && inst_ready) begin
                e = exp_q.pop_front();
                n_total++;
                if ({inst_pc, inst} !== e) $display("FAIL drop_pop got=%h/%h exp=%h/%h", inst_pc, inst, e[63:32], e[31:0]);
                else n_pass++;
            end
            @(negedge clk);
        end
        n_total++;
        if (ack_addr.size() < 2) $display("FAIL drop_acks got=%0d exp=2", ack_addr.size());
        else if (ack_addr[0] !== 32'h0 || ack_addr[1] !== 32'h100)
            $display("FAIL drop_addrs got=%h,%h exp=00000000,00000100", ack_addr[0], ack_addr[1]);
        else n_pass++;
    endtask

    task automatic test_redirect_ack_pop();
        logic [63:0] e;
        int acks;
        logic hit;
        mem_wait = 0;
        inst_ready = 1'b0;
        exp_q.delete();
        do_reset();
        acks = 0;
        hit = 1'b0;
        for (int c = 0; c < 20 && !hit; c++) begin
            if (imem_req && imem_ack && inst_valid && acks == 2) hit = 1'b1;
            else begin
                if (imem_req && imem_ack) acks++;
                @(negedge clk);
            end
        end
        n_total++; if (!hit) $display("FAIL rap_setup got=0 exp=1"); else n_pass++;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0200;
        inst_ready = 1'b1;
        @(negedge clk);
        redirect = 1'b0;
        inst_ready = 1'b0;
        n_total++; if (inst_valid !== 1'b0) $display("FAIL rap_empty got=%b exp=0", inst_valid); else n_pass++;
        @(negedge clk);
        n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) $display("FAIL rap_req got=%b/%h exp=1/00000200", imem_req, imem_addr); else n_pass++;
        exp_q.push_back({32'h200, mem_word(32'h200)});
        inst_ready = 1'b1;
        @(negedge clk);
        n_total++; if (inst_valid !== 1'b1) $display("FAIL rap_latency got=%b exp=1", inst_valid); else n_pass++;
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
            if (inst_valid && inst_ready) begin
                e = exp_q.pop_front();
                n_total++;
                if ({inst_pc, inst} !== e) $display("FAIL rap_pop got=%h/%h exp=%h/%h", inst_pc, inst, e[63:32], e[31:0]);
                else n_pass++;
            end
            @(negedge clk);
        end
        n_total++; if (exp_q.size() != 0) $display("FAIL rap_timeout left=%0d exp=0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [63:0] e;
        mem_wait = 0;
        inst_ready = 1'b1;
        exp_q.delete();
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        exp_q.push_back({32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC)});
        exp_q.push_back({32'h0, mem_word(32'h0)});
        exp_q.push_back({32'h4, mem_word(32'h4)});
        @(negedge clk);
        redirect = 1'b0;
        for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
            if (inst_valid && inst_ready) begin
                e = exp_q.pop_front();
                n_total++;
                if ({inst_pc, inst} !== e) $display("FAIL wrap_pop got=%h/%h exp=%h/%h", inst_pc, inst, e[63:32], e[31:0]);
                else n_pass++;
            end
            @(negedge clk);
        end
        n_total++; if (exp_q.size() != 0) $display("FAIL wrap_timeout left=%0d exp=0", exp_q.size()); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int acks;
        logic hit;
        mem_wait = 2;
        inst_ready = 1'b0;
        do_reset();
        acks = 0;
        hit = 1'b0;
        for (int c = 0; c < 30 && !hit; c++) begin
            if (imem_req && !imem_ack && acks == 2) hit = 1'b1;
            else begin
                if (imem_req && imem_ack) acks++;
                @(negedge clk);
            end
        end
        n_total++; if (!hit || inst_valid !== 1'b1) $display("FAIL mid_setup got=%b/%b exp=1/1", hit, inst_valid); else n_pass++;
        #2;
        rst = 1'b0;
        #1;
        n_total++; if (imem_req !== 1'b0) $display("FAIL mid_req got=%b exp=0", imem_req); else n_pass++;
        n_total++; if (inst_valid !== 1'b0) $display("FAIL mid_valid got=%b exp=0", inst_valid); else n_pass++;
        n_total++; if (inst !== 32'h0 || inst_pc !== 32'h0) $display("FAIL mid_head got=%h/%h exp=0/0", inst, inst_pc); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL mid_restart got=%b/%h exp=1/00000000", imem_req, imem_addr); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_drop();
        test_redirect_ack_pop();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
